// File: rtl/updown_counter_mm.sv
// Parametrised up/down counter with programmable limit and step, wrap/saturate/one-shot
// modes, a one-cycle wrap pulse and a RUN/DONE terminal FSM for one-shot counting.
module updown_counter_mm #(
  parameter int N = 8,
  parameter int S = 8
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_en,
  input  logic         i_load,
  input  logic         i_dir,
  input  logic [1:0]   i_mode,
  input  logic [S-1:0] i_step,
  input  logic [N-1:0] i_limit,
  input  logic [N-1:0] i_data,
  output logic [N-1:0] o_result,
  output logic         o_full,
  output logic         o_empty,
  output logic         o_wrap,
  output logic         o_done,
  output logic         o_dbg_state
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  localparam logic [N:0] ONE = {{N{1'b0}}, 1'b1};

  state_t       state_q, state_d;
  logic [N-1:0] result_d;
  logic         wrap_d;

  // All arithmetic is one bit wider than the counter so limit = all-ones cannot overflow.
  logic [N:0] lim, stp_raw, stp, cur, data_x, sum, cnt_val;
  logic       wrap_mode, one_shot, in_range, up_wrap, dn_wrap;

  assign lim       = {1'b0, i_limit};
  assign stp_raw   = {{(N + 1 - S){1'b0}}, i_step};
  assign stp       = (stp_raw > lim) ? lim : stp_raw;
  assign cur       = {1'b0, o_result};
  assign data_x    = {1'b0, i_data};
  assign sum       = cur + stp;
  assign in_range  = (cur <= lim);
  assign one_shot  = (i_mode == 2'b10);
  assign wrap_mode = (i_mode != 2'b01) && (i_mode != 2'b10);

  always_comb begin
    up_wrap = wrap_mode && (sum > lim);
    dn_wrap = wrap_mode && (stp > cur);
    cnt_val = cur;
    if (i_dir) begin
      if (up_wrap)         cnt_val = sum - (lim + ONE);
      else if (sum > lim)  cnt_val = lim;
      else                 cnt_val = sum;
    end else begin
      if (dn_wrap)         cnt_val = cur + lim + ONE - stp;
      else if (stp > cur)  cnt_val = '0;
      else                 cnt_val = cur - stp;
    end
  end

  // Priority with enable: load, then out-of-range clamp, then count (RUN only).
  always_comb begin
    result_d = o_result;
    wrap_d   = 1'b0;
    state_d  = state_q;
    if (i_en) begin
      if (i_load) begin
        result_d = (data_x > lim) ? i_limit : i_data;
        state_d  = ST_RUN;
      end else begin
        if (state_q == ST_DONE && !one_shot) state_d = ST_RUN;
        if (!in_range) begin
          result_d = i_limit;
        end else if (state_q == ST_RUN) begin
          result_d = cnt_val[N-1:0];
          wrap_d   = i_dir ? up_wrap : dn_wrap;
          if (one_shot && (i_dir ? (cnt_val == lim) : (cnt_val == '0)))
            state_d = ST_DONE;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      o_result <= '0;
      o_wrap   <= 1'b0;
      state_q  <= ST_RUN;
    end else begin
      o_result <= result_d;
      o_wrap   <= wrap_d;
      state_q  <= state_d;
    end
  end

  assign o_done      = (state_q == ST_DONE);
  assign o_dbg_state = state_q;
  assign o_full      = (o_result == i_limit);
  assign o_empty     = (o_result == '0);

endmodule

// File: tb/tb_updown_counter_mm.sv
// Bench for updown_counter_mm: directed scenario tasks checked against fixed values,
// then randomized traffic checked against an integer reference model.
module tb_updown_counter_mm;
  localparam int N = 8;
  localparam int S = 8;

  logic         i_clk = 1'b0;
  logic         i_rstn, i_en, i_load, i_dir;
  logic [1:0]   i_mode;
  logic [S-1:0] i_step;
  logic [N-1:0] i_limit, i_data;
  logic [N-1:0] o_result;
  logic         o_full, o_empty, o_wrap, o_done, o_dbg_state;

  int total = 0;
  int bad   = 0;
  int exp_res  = 0;
  bit exp_wrap = 1'b0;
  bit exp_done = 1'b0;

  updown_counter_mm #(.N(N), .S(S)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_en(i_en), .i_load(i_load), .i_dir(i_dir),
    .i_mode(i_mode), .i_step(i_step), .i_limit(i_limit), .i_data(i_data),
    .o_result(o_result), .o_full(o_full), .o_empty(o_empty), .o_wrap(o_wrap),
    .o_done(o_done), .o_dbg_state(o_dbg_state)
  );

  always #5 i_clk = ~i_clk;

  // Reference model: integer arithmetic straight from the counting rules.
  task automatic model_step();
    int lim, stp, r, nv;
    lim = int'(i_limit);
    stp = (int'(i_step) < lim) ? int'(i_step) : lim;
    r   = exp_res;
    exp_wrap = 1'b0;
    if (!i_rstn) begin
      exp_res = 0; exp_done = 1'b0;
    end else if (!i_en) begin
      // hold
    end else if (i_load) begin
      exp_res  = (int'(i_data) < lim) ? int'(i_data) : lim;
      exp_done = 1'b0;
    end else begin
      bit was_done = exp_done;
      if (exp_done && i_mode != 2'b10) exp_done = 1'b0;
      if (r > lim) exp_res = lim;
      else if (!was_done) begin
        if (i_dir) begin
          nv = r + stp;
          if (i_mode == 2'b01 || i_mode == 2'b10) begin
            if (nv > lim) nv = lim;
          end else if (nv > lim) begin
            nv = nv - (lim + 1); exp_wrap = 1'b1;
          end
        end else begin
          if (i_mode == 2'b01 || i_mode == 2'b10) nv = (stp > r) ? 0 : r - stp;
          else if (stp > r) begin
            nv = r + lim + 1 - stp; exp_wrap = 1'b1;
          end else nv = r - stp;
        end
        exp_res = nv;
        if (i_mode == 2'b10 && ((i_dir && nv == lim) || (!i_dir && nv == 0))) exp_done = 1'b1;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_in(bit en, bit load, bit dir, logic [1:0] mode, int step, int limit, int data);
    i_en = en; i_load = load; i_dir = dir; i_mode = mode;
    i_step = S'(step); i_limit = N'(limit); i_data = N'(data);
  endtask

  task automatic test_reset();
    i_rstn = 1'b0;
    set_in(1, 1, 1, 2'b00, 3, 9, 77);
    tick(); tick();
    total++;
    if (o_result !== 8'd0 || o_wrap !== 1'b0 || o_done !== 1'b0 || o_empty !== 1'b1) begin
      bad++;
      $display("FAIL reset got res=%0d wrap=%b done=%b empty=%b exp res=0 wrap=0 done=0 empty=1",
               o_result, o_wrap, o_done, o_empty);
    end
    i_rstn = 1'b1;
  endtask

  task automatic test_wrap_up();
    int er[4] = '{3, 6, 9, 2};
    bit ew[4] = '{0, 0, 0, 1};
    bit ef[4] = '{0, 0, 1, 0};
    set_in(1, 0, 1, 2'b00, 3, 9, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (o_result !== N'(er[i]) || o_wrap !== ew[i] || o_full !== ef[i]) begin
        bad++;
        $display("FAIL wrap_up[%0d] got res=%0d wrap=%b full=%b exp res=%0d wrap=%b full=%b",
                 i, o_result, o_wrap, o_full, er[i], ew[i], ef[i]);
      end
    end
  endtask

  task automatic test_wrap_down();
    set_in(1, 1, 0, 2'b00, 1, 255, 0);
    tick();
    set_in(1, 0, 0, 2'b00, 1, 255, 0);
    tick();
    total++;
    if (o_result !== 8'd255 || o_wrap !== 1'b1 || o_full !== 1'b1) begin
      bad++;
      $display("FAIL wrap_down got res=%0d wrap=%b full=%b exp res=255 wrap=1 full=1", o_result, o_wrap, o_full);
    end
    i_en = 1'b0;
    tick();
    total++;
    if (o_result !== 8'd255 || o_wrap !== 1'b0) begin
      bad++;
      $display("FAIL wrap_pulse_len got res=%0d wrap=%b exp res=255 wrap=0", o_result, o_wrap);
    end
    set_in(1, 1, 1, 2'b00, 255, 255, 1);
    tick();
    set_in(1, 0, 1, 2'b00, 255, 255, 1);
    tick();
    total++;
    if (o_result !== 8'd0 || o_wrap !== 1'b1 || o_empty !== 1'b1) begin
      bad++;
      $display("FAIL wrap_up_full got res=%0d wrap=%b empty=%b exp res=0 wrap=1 empty=1", o_result, o_wrap, o_empty);
    end
  endtask

  task automatic test_saturate();
    int er[8] = '{40, 80, 100, 100, 60, 20, 0, 0};
    set_in(1, 1, 1, 2'b01, 40, 100, 0);
    tick();
    for (int i = 0; i < 8; i++) begin
      set_in(1, 0, (i < 4), 2'b01, 40, 100, 0);
      tick();
      total++;
      if (o_result !== N'(er[i]) || o_wrap !== 1'b0) begin
        bad++;
        $display("FAIL saturate[%0d] got res=%0d wrap=%b exp res=%0d wrap=0", i, o_result, o_wrap, er[i]);
      end
    end
    total++;
    if (o_empty !== 1'b1) begin
      bad++;
      $display("FAIL saturate_empty got %b exp 1", o_empty);
    end
  endtask

  task automatic test_one_shot();
    int er[7] = '{2, 4, 5, 5, 5, 1, 3};
    bit ed[7] = '{0, 0, 1, 1, 1, 0, 0};
    set_in(1, 1, 1, 2'b10, 2, 5, 0);
    tick();
    for (int i = 0; i < 7; i++) begin
      set_in(1, (i == 5), 1, 2'b10, 2, 5, 1);
      tick();
      total++;
      if (o_result !== N'(er[i]) || o_done !== ed[i] || o_wrap !== 1'b0) begin
        bad++;
        $display("FAIL one_shot[%0d] got res=%0d done=%b wrap=%b exp res=%0d done=%b wrap=0",
                 i, o_result, o_done, o_wrap, er[i], ed[i]);
      end
    end
  endtask

  task automatic test_priority();
    set_in(1, 1, 1, 2'b01, 10, 150, 200);
    tick();
    total++;
    if (o_result !== 8'd150) begin
      bad++;
      $display("FAIL load_clip got res=%0d exp 150", o_result);
    end
    set_in(1, 0, 1, 2'b00, 3, 50, 0);
    tick();
    total++;
    if (o_result !== 8'd50 || o_wrap !== 1'b0 || o_full !== 1'b1) begin
      bad++;
      $display("FAIL clamp got res=%0d wrap=%b full=%b exp res=50 wrap=0 full=1", o_result, o_wrap, o_full);
    end
    i_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (o_result !== 8'd50 || o_wrap !== 1'b0) begin
        bad++;
        $display("FAIL enable_hold[%0d] got res=%0d wrap=%b exp res=50 wrap=0", i, o_result, o_wrap);
      end
    end
    set_in(1, 0, 0, 2'b00, 0, 50, 0);
    tick();
    total++;
    if (o_result !== 8'd50 || o_wrap !== 1'b0) begin
      bad++;
      $display("FAIL step_zero got res=%0d wrap=%b exp res=50 wrap=0", o_result, o_wrap);
    end
  endtask

  task automatic test_back_to_back();
    int er[5] = '{4, 3, 2, 1, 0};
    bit ew[5] = '{0, 1, 1, 1, 1};
    set_in(1, 1, 1, 2'b00, 4, 4, 0);
    tick();
    set_in(1, 0, 1, 2'b00, 4, 4, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (o_result !== N'(er[i]) || o_wrap !== ew[i]) begin
        bad++;
        $display("FAIL back_to_back[%0d] got res=%0d wrap=%b exp res=%0d wrap=%b", i, o_result, o_wrap, er[i], ew[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    set_in(1, 1, 1, 2'b10, 5, 5, 0);
    tick();
    set_in(1, 0, 1, 2'b10, 5, 5, 0);
    tick();
    total++;
    if (o_result !== 8'd5 || o_done !== 1'b1) begin
      bad++;
      $display("FAIL reach_done got res=%0d done=%b exp res=5 done=1", o_result, o_done);
    end
    i_rstn = 1'b0;
    tick();
    total++;
    if (o_result !== 8'd0 || o_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid got res=%0d done=%b exp res=0 done=0", o_result, o_done);
    end
    i_rstn = 1'b1;
    set_in(1, 0, 1, 2'b10, 2, 5, 0);
    tick();
    total++;
    if (o_result !== 8'd2 || o_done !== 1'b0) begin
      bad++;
      $display("FAIL resume got res=%0d done=%b exp res=2 done=0", o_result, o_done);
    end
  endtask

  task automatic test_random();
    int lim_pick;
    lim_pick = 20;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 4))
          0: lim_pick = 0;
          1: lim_pick = 1;
          2: lim_pick = 255;
          default: lim_pick = $urandom_range(0, 255);
        endcase
      end
      i_rstn = ($urandom_range(0, 60) != 0);
      set_in(($urandom_range(0, 7) != 0), ($urandom_range(0, 11) == 0), $urandom_range(0, 1),
             2'($urandom_range(0, 3)),
             ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 6),
             lim_pick, $urandom_range(0, 255));
      tick();
      total++;
      if (o_result !== exp_res[N-1:0] || o_wrap !== exp_wrap || o_done !== exp_done ||
          o_full !== (exp_res == lim_pick) || o_empty !== (exp_res == 0)) begin
        bad++;
        $display("FAIL random[%0d] got res=%0d wrap=%b done=%b full=%b empty=%b exp res=%0d wrap=%b done=%b lim=%0d",
                 i, o_result, o_wrap, o_done, o_full, o_empty, exp_res, exp_wrap, exp_done, lim_pick);
      end
    end
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_saturate();
    test_one_shot();
    test_priority();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/updown_counter_mm.md
Name: updown_counter_mm

Overview:
Parametrised up/down counter, next generation of the team's basic enable/load/direction counter. Adds a programmable upper limit, a programmable step, three count modes (wrap, saturate, one-shot) and a wrap-event pulse. The one-shot mode is handled by a two-state run/done FSM. Intended as the general-purpose event/timeout counter in datapath and control blocks; pairs with a bound FPV checker.

Parameters:
N, 8, counter width in bits (N >= 2)
S, 8, step input width in bits (1 <= S <= N)

Ports:
i_clk  input  1  clock, all state updates on rising edge
i_rstn  input  1  reset, synchronous, active-low
i_en  input  1  global enable; when 0, counter, FSM and o_wrap hold/clear as below
i_load  input  1  load i_data (effective only with i_en=1)
i_dir  input  1  1 = increment, 0 = decrement
i_mode  input  2  00 wrap, 01 saturate, 10 one-shot, 11 reserved (treated as wrap)
i_step  input  S  count step, zero-extended to N bits
i_limit  input  N  upper bound of count range [0, i_limit]
i_data  input  N  load value
o_result  output  N  counter value (registered)
o_full  output  1  o_result == i_limit (combinational)
o_empty  output  1  o_result == 0 (combinational)
o_wrap  output  1  one-cycle pulse, high in the cycle the wrapped value is first visible on o_result
o_done  output  1  one-shot terminal reached (registered level)

Behaviour:
- Reset (i_rstn=0 at posedge): o_result=0, o_wrap=0, o_done=0, FSM=RUN. Overrides all other inputs. Reset mid-count or in DONE returns to RUN.
- Effective step: stp = min(i_step, i_limit). All arithmetic in N+1 bits, with no intermediate overflow. i_limit = all-ones is legal.
- Priority at each edge with i_en=1: load > out-of-range clamp > count.
- i_en=0: o_result, o_done and FSM hold; o_wrap=0 next cycle.
- Load: o_result <= min(i_data, i_limit) next cycle; o_wrap=0; FSM -> RUN, o_done <= 0. The load is honoured in any mode and state.
- Clamp: if o_result > i_limit (limit lowered at runtime) and no load, o_result <= i_limit; o_wrap=0.
- Count (no load, in range, FSM=RUN):
  - Up: sum = o_result + stp.
    - Wrap mode: if sum > i_limit then o_result <= sum - (i_limit+1) and o_wrap <= 1; else o_result <= sum.
    - Saturate/one-shot modes: o_result <= min(sum, i_limit).
  - Down:
    - Wrap mode: if stp > o_result then o_result <= o_result + i_limit + 1 - stp and o_wrap <= 1; else o_result <= o_result - stp.
    - Saturate/one-shot modes: o_result <= max(o_result - stp, 0).
  - stp=0: o_result holds, no wrap.
  - i_limit=0: o_result stays 0, o_wrap never asserts.
- FSM (states RUN, DONE):
  - RUN -> DONE: in i_mode=10, a count (not a load) makes the next o_result equal i_limit (up) or 0 (down). o_done <= 1 in the same edge.
  - DONE: counting is ignored and o_result holds. Clamp still applies.
  - DONE -> RUN: on a load, or when i_mode != 10 with i_en=1; o_done <= 0 on the same edge.
- o_wrap: high for exactly one cycle per wrap event. Back-to-back wraps give consecutive high cycles. o_wrap is never high outside wrap mode.
- Latency: one cycle from input edge to o_result/o_wrap/o_done. o_full/o_empty follow o_result and i_limit combinationally.
- The o_full and o_empty flags are not sticky.

Test Plan:
- Reset, then wrap up: N=8, limit=9, step=3, dir=1, mode=00, en=1 from 0 -> o_result 3,6,9,2 with o_wrap=1 only at 2. o_full=1 at 9.
- Wrap down with full range: limit=255, step=1, dir=0, from 0 -> o_result=255, o_wrap=1 one cycle, o_full=1. Repeat with limit=255, step=255 up from 1 -> o_result 0, o_wrap=1.
- Saturate: limit=100, step=40, dir=1, mode=01 from 0 -> 40,80,100,100, o_wrap=0 throughout. Then dir=0 -> 60,20,0,0, with o_empty=1.
- One-shot: mode=10, limit=5, step=2, dir=1 from 0 -> 2,4,5 with o_done=1 at 5. Further enabled cycles hold 5. Load i_data=1 -> o_result=1, o_done=0, counting resumes at 3.
- Priority and boundaries:
  - load+count in same cycle with i_data=200, limit=150 -> o_result=150.
  - Lower limit from 150 to 50 while o_result=150 -> next o_result=50, no wrap.
  - i_en=0 for 3 cycles -> o_result stable, o_wrap=0.
  - Step=0 -> hold.
- Reset mid-operation: assert i_rstn=0 while in DONE with o_result=5 -> next edge o_result=0, o_done=0. After release, counting resumes from 0 in RUN.
